ws2811_frame_buffer: RTL and testbench
======================================

Name: ws2811_frame_buffer

Overview:
- Double-buffered pixel store directly upstream of the WS2811 array controller.
- A host writes 24-bit RGB pixels into the back bank and requests a bank swap.
- On each controller frame request, the block streams the front bank pixel by pixel over a valid/ready handshake, feeding the controller's serializer.
- Swaps take effect only at frame boundaries, so a frame on the wire is never torn.

Parameters:
- MAX_LEDS, 256: pixel slots per bank.
- ADDR_W, 8: pixel index width; 2^ADDR_W >= MAX_LEDS.
- DATA_W, 24: pixel width, {R[23:16], G[15:8], B[7:0]}.

Ports:
- clock  in  1  system clock, 50 MHz, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host pixel write strobe.
- wr_addr  in  ADDR_W  host pixel index, back bank.
- wr_data  in  DATA_W  host pixel value.
- swap_req  in  1  one-cycle pulse requesting front/back exchange.
- swap_pending  out  1  swap requested but not yet performed.
- led_count  in  ADDR_W  pixels per frame; sampled on frame_start.
- frame_start  in  1  one-cycle pulse from the controller requesting one frame.
- pix_valid  out  1  pix_data holds a pixel.
- pix_ready  in  1  controller accepts the pixel.
- pix_data  out  DATA_W  pixel value.
- pix_last  out  1  qualifies the final pixel of the frame.
- busy  out  1  frame streaming in progress.
- bank_sel  out  1  index of the current front bank.

Behaviour:
- Reset (reset low, asynchronous): pix_valid=0, pix_data=0, pix_last=0, busy=0, swap_pending=0, bank_sel=0, FSM=IDLE. Memory contents are not cleared.
- Storage:
  - Two banks of MAX_LEDS x DATA_W with synchronous-read inference.
  - Front bank = bank_sel; back bank = ~bank_sel.
- Host writes:
  - When wr_en is high, the write lands in the back bank at wr_addr in the same cycle.
  - Writes are accepted in every state, including during streaming.
  - A write on the same cycle as a swap lands in the pre-swap back bank, which becomes the front bank.
- Swap:
  - swap_req sets swap_pending.
  - The swap executes (bank_sel toggles, swap_pending clears) on the first cycle the FSM is in IDLE with swap_pending set.
  - Swap has priority over frame_start arriving in the same cycle, so that frame streams the new front bank.
  - swap_req while swap_pending is already set has no extra effect; swaps do not accumulate.
- FSM states:
  - IDLE: busy=0. On frame_start with led_count!=0, latch count=led_count, set idx=0, go to FETCH. frame_start with led_count==0 is ignored and produces no pix_valid.
  - FETCH: issue a read of front[idx]; busy=1; go to PRESENT next cycle.
  - PRESENT: drive pix_valid=1, pix_data=read data, pix_last=(idx==count-1).
    - Hold all outputs stable until pix_ready is high.
    - On acceptance (valid & ready): if pix_last, go to IDLE and deassert valid and last on the next cycle; otherwise idx++ and go to FETCH.
- frame_start while busy is ignored.
- Latency: frame_start at edge T gives pix_valid at edge T+2. Each accepted pixel gives the next pix_valid 2 cycles later; throughput is 1 pixel per 2 clocks, far above the WS2811 bit rate.
- Index arithmetic: idx is ADDR_W wide and never wraps, because count <= 2^ADDR_W - 1.
- Mid-frame reset: streaming aborts immediately and all outputs take reset values. The controller restarts by issuing a new frame_start.

Optional Feature:
- Macro: WS2811_BRIGHTNESS_SCALE_EN.
- Defined:
  - Adds input port brightness [7:0] and one pipeline stage between FETCH and PRESENT, giving latency T+3.
  - Each channel is scaled as out = (chan * (brightness + 1)) >> 8, computed at 16 bits and truncated to 8.
  - brightness=255 passes data unchanged; brightness=0 gives chan>>8 = 0.
  - brightness is sampled in the scaling stage of each pixel.
- Undefined: no port, no stage; pix_data equals the stored value exactly.

Test Plan:
- Reset/idle: hold reset low 100 cycles -> all outputs 0, bank_sel=0; release, then frame_start with led_count=0 -> pix_valid never rises, busy stays 0.
- Basic stream:
  - Write pixels 0..3 = 0x110000, 0x002200, 0x000033, 0xABCDEF; pulse swap_req; frame_start with led_count=4 and pix_ready held high.
  - Expect 4 pix_valid beats in order, pix_last only on 0xABCDEF, first valid 2 cycles after frame_start, bank_sel=1.
- Backpressure: pix_ready low for 10 cycles on pixel 1 -> pix_valid stays 1 and pix_data stays 0x002200 throughout; no pixel is skipped or duplicated.
- Deferred swap:
  - Pulse swap_req during pixel 2 of a 4-pixel frame -> swap_pending=1 until the cycle after pix_last acceptance, then bank_sel toggles.
  - Writes made during the frame do not appear in the current frame.
- Simultaneous events: swap_req and frame_start in the same IDLE cycle -> the frame streams the newly swapped bank's contents.
- Brightness (with macro): pixel 0xFF8040 with brightness=127 -> pix_data=0x7F4020, first valid 3 cycles after frame_start.

Source files
------------

// File: rtl/ws2811_frame_buffer.sv
// Double-buffered WS2811 pixel store: host fills the back bank, the front bank
// streams over valid/ready. Optional WS2811_BRIGHTNESS_SCALE_EN adds a scaling stage.
module ws2811_frame_buffer #(
    parameter int MAX_LEDS = 256,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 24
) (
`ifdef WS2811_BRIGHTNESS_SCALE_EN
    input  logic [7:0]        i_brightness,
`endif
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_swap_req,
    output logic              o_swap_pending,
    input  logic [ADDR_W-1:0] i_led_count,
    input  logic              i_frame_start,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_last,
    output logic              o_busy,
    output logic              o_bank_sel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SCALE,
        S_PRESENT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_bank0 [MAX_LEDS];
    logic [DATA_W-1:0] r_bank1 [MAX_LEDS];

    logic              r_bank_sel;
    logic              r_swap_pending;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_rd_data;

    logic w_swap_now;
    logic w_start;
    logic w_accept;
    logic w_last;

    // Swaps only happen while idle; a request in the same cycle counts too,
    // so a coincident frame_start streams the freshly swapped bank.
    assign w_swap_now = (r_state == S_IDLE) && (r_swap_pending || i_swap_req);
    assign w_start    = (r_state == S_IDLE) && i_frame_start &&
                        (i_led_count != '0);
    assign w_accept   = (r_state == S_PRESENT) && i_pix_ready;
    assign w_last     = (r_idx == (r_count - ADDR_W'(1)));

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
`ifdef WS2811_BRIGHTNESS_SCALE_EN
                w_next = S_SCALE;
`else
                w_next = S_PRESENT;
`endif
            end
            S_SCALE: begin
                w_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_accept) begin
                    w_next = w_last ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Host writes always target the back bank (pre-swap bank on a swap cycle)
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            if (r_bank_sel) begin
                r_bank0[i_wr_addr] <= i_wr_data;
            end else begin
                r_bank1[i_wr_addr] <= i_wr_data;
            end
        end
    end

    // Bank selection and deferred swap bookkeeping
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_bank_sel     <= 1'b0;
            r_swap_pending <= 1'b0;
        end else if (w_swap_now) begin
            r_bank_sel     <= ~r_bank_sel;
            r_swap_pending <= 1'b0;
        end else if (i_swap_req) begin
            r_swap_pending <= 1'b1;
        end
    end

    // Frame length latch and pixel index
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
            r_idx   <= '0;
        end else if (w_start) begin
            r_count <= i_led_count;
            r_idx   <= '0;
        end else if (w_accept && !w_last) begin
            r_idx   <= r_idx + ADDR_W'(1);
        end
    end

    // Synchronous read of the front bank
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_data <= '0;
        end else if (r_state == S_FETCH) begin
            r_rd_data <= r_bank_sel ? r_bank1[r_idx] : r_bank0[r_idx];
        end
    end

`ifdef WS2811_BRIGHTNESS_SCALE_EN
    logic [DATA_W-1:0] r_scaled;

    function automatic logic [7:0] f_scale(input logic [7:0] c,
                                           input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    // Per-channel brightness scaling, brightness sampled in this stage
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_scaled <= '0;
        end else if (r_state == S_SCALE) begin
            r_scaled <= {f_scale(r_rd_data[23:16], i_brightness),
                         f_scale(r_rd_data[15:8],  i_brightness),
                         f_scale(r_rd_data[7:0],   i_brightness)};
        end
    end

    assign o_pix_data = r_scaled;
`else
    assign o_pix_data = r_rd_data;
`endif

    assign o_pix_valid    = (r_state == S_PRESENT);
    assign o_pix_last     = (r_state == S_PRESENT) && w_last;
    assign o_busy         = (r_state != S_IDLE);
    assign o_bank_sel     = r_bank_sel;
    assign o_swap_pending = r_swap_pending;

endmodule

// File: tb/tb_ws2811_frame_buffer.sv
// Randomized bench for ws2811_frame_buffer against a bank/queue reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ws2811_frame_buffer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        swap_req;
    logic        swap_pending;
    logic [7:0]  led_count;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_last;
    logic        busy;
    logic        bank_sel;
`ifdef WS2811_BRIGHTNESS_SCALE_EN
    logic [7:0]  bright;
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    ws2811_frame_buffer dut (
`ifdef WS2811_BRIGHTNESS_SCALE_EN
        .i_brightness   (bright),
`endif
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_swap_req     (swap_req),
        .o_swap_pending (swap_pending),
        .i_led_count    (led_count),
        .i_frame_start  (frame_start),
        .o_pix_valid    (pix_valid),
        .i_pix_ready    (pix_ready),
        .o_pix_data     (pix_data),
        .o_pix_last     (pix_last),
        .o_busy         (busy),
        .o_bank_sel     (bank_sel)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [23:0] mb [2][256];
    int          msel;
    bit          mpend;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [23:0] pix_model(input logic [23:0] v);
`ifdef WS2811_BRIGHTNESS_SCALE_EN
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            r[c*8 +: 8] = 8'((int'(v[c*8 +: 8]) * (int'(bright) + 1)) / 256);
        end
        return r;
`else
        return v;
`endif
    endfunction

    task automatic write_px(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = 8'(a);
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
        mb[msel ^ 1][a] = d;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        msel ^= 1;
        check("swap_sel", bank_sel, msel);
        check("swap_pend", swap_pending, 0);
    endtask

    task automatic run_frame(input int n, input int ready_pct,
                             input int stall_beat, input int mid_at,
                             input bit with_swap);
        logic [23:0] expq[$];
        int beat;
        int guard;
        int stalled;
        bit mid_done;
        bit rdy;
        int a;
        logic [23:0] d;
        if (with_swap) msel ^= 1;
        for (int i = 0; i < n; i++) expq.push_back(pix_model(mb[msel][i]));
        frame_start = 1'b1;
        led_count   = 8'(n);
        swap_req    = with_swap;
        cyc();
        frame_start = 1'b0;
        swap_req    = 1'b0;
        led_count   = 8'($urandom);
        check("start_sel", bank_sel, msel);
        check("start_busy", busy, 1);
        for (int k = 0; k < LAT - 1; k++) begin
            check("lat_early", pix_valid, 0);
            cyc();
        end
        check("lat_valid", pix_valid, 1);
        beat = 0;
        guard = 0;
        stalled = 0;
        mid_done = 0;
        while (beat < n && guard < 4000) begin
            guard++;
            if (pix_valid) begin
                check("data", pix_data, expq[beat]);
                check("last", pix_last, (beat == n - 1));
                if (beat == stall_beat && stalled < 10) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(99) < ready_pct);
                end
                if (beat == mid_at && !mid_done) begin
                    a = $urandom_range(31);
                    d = 24'($urandom);
                    swap_req = 1'b1;
                    wr_en    = 1'b1;
                    wr_addr  = 8'(a);
                    wr_data  = d;
                    mb[msel ^ 1][a] = d;
                    mpend    = 1'b1;
                    mid_done = 1'b1;
                end
                pix_ready = rdy;
                cyc();
                swap_req = 1'b0;
                wr_en    = 1'b0;
                if (rdy) beat++;
            end else begin
                check("gap_busy", busy, 1);
                pix_ready = 1'($urandom);
                cyc();
            end
        end
        if (guard >= 4000) check("timeout", 0, 1);
        pix_ready = 1'b0;
        check("end_valid", pix_valid, 0);
        check("end_last", pix_last, 0);
        check("end_busy", busy, 0);
        if (mpend) begin
            check("defer_pend", swap_pending, 1);
            check("defer_old_sel", bank_sel, msel);
            cyc();
            msel ^= 1;
            mpend = 1'b0;
        end
        check("post_sel", bank_sel, msel);
        check("post_pend", swap_pending, 0);
    endtask

    initial begin
        bit saw;
        int n;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; led_count = '0; frame_start = 1'b0; pix_ready = 1'b0;
`ifdef WS2811_BRIGHTNESS_SCALE_EN
        bright = 8'd255;
`endif
        msel = 0; mpend = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) mb[b][i] = '0;

        repeat (100) cyc();
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_last", pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", swap_pending, 0);
        check("rst_sel", bank_sel, 0);
        rst_n = 1'b1;
        cyc();

        frame_start = 1'b1; led_count = 8'd0; pix_ready = 1'b1;
        cyc();
        frame_start = 1'b0;
        saw = 0;
        repeat (6) begin
            if (pix_valid || busy) saw = 1;
            cyc();
        end
        check("zero_len", saw, 0);
        pix_ready = 1'b0;

        for (int i = 0; i < 32; i++) write_px(i, 24'($urandom));
        do_swap();
        for (int i = 0; i < 32; i++) write_px(i, 24'($urandom));
        do_swap();

        write_px(0, 24'h110000);
        write_px(1, 24'h002200);
        write_px(2, 24'h000033);
        write_px(3, 24'hABCDEF);
        do_swap();
        check("basic_sel", bank_sel, 1);
        run_frame(4, 100, -1, -1, 0);
        run_frame(4, 100, 1, -1, 0);
        run_frame(4, 100, -1, 2, 0);
        for (int i = 0; i < 4; i++) write_px(i, 24'($urandom));
        run_frame(4, 100, -1, -1, 1);

        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(4)) write_px($urandom_range(31), 24'($urandom));
            if ($urandom_range(1)) do_swap();
`ifdef WS2811_BRIGHTNESS_SCALE_EN
            bright = 8'($urandom);
`endif
            n = $urandom_range(32, 1);
            run_frame(n, 50, -1, ($urandom_range(1) ? $urandom_range(n - 1) : -1),
                      1'($urandom_range(1)));
        end

`ifdef WS2811_BRIGHTNESS_SCALE_EN
        write_px(0, 24'hFF8040);
        do_swap();
        bright = 8'd127;
        run_frame(1, 100, -1, -1, 0);
        check("bright_model", pix_model(24'hFF8040), 24'h7F4020);
        bright = 8'd255;
`endif

        frame_start = 1'b1; led_count = 8'd16; pix_ready = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (5) cyc();
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sel", bank_sel, 0);
        msel = 0; mpend = 1'b0;
        pix_ready = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        run_frame(3, 70, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
